// File: rtl/transpose_buf.sv
// Ping-pong N x N transpose buffer: row-major samples in, column-major (MODE=1) or
// row-major (MODE=0) samples out, valid/ready on both sides.
module transpose_buf #(
    parameter int DATA_WIDTH = 10,
    parameter int N          = 8,
    parameter int MODE       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_load,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [1:0]            full_cnt
);

    localparam int NN = N * N;
    localparam int AW = $clog2(NN);
    localparam int LN = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(NN - 1);

    logic [DATA_WIDTH-1:0] mem [2][NN];

    logic          wb;
    logic          rb;
    logic [AW-1:0] wc;
    logic [AW-1:0] rc;
    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic [AW-1:0] rd_idx;
    logic          wr_fire;
    logic          rd_load;

    assign in_ready = ~full[wb];
    assign wr_fire  = in_load & in_ready;
    assign rd_load  = full[rb] & (~out_valid | out_ready);
    assign full_cnt = {1'b0, full[0]} + {1'b0, full[1]};

    // Column-major index (rc mod N)*N + rc/N is a swap of the two log2(N)-bit halves of rc.
    always_comb begin
        rd_idx = rc;
        if (MODE != 0) begin
            rd_idx = {rc[LN-1:0], rc[AW-1:LN]};
        end
    end

    // Writer and reader always target different banks, so set and clear never collide.
    always_comb begin
        full_nxt = full;
        if (wr_fire && (wc == LAST)) begin
            full_nxt[wb] = 1'b1;
        end
        if (rd_load && (rc == LAST)) begin
            full_nxt[rb] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wb][wc] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb        <= 1'b0;
            rb        <= 1'b0;
            wc        <= '0;
            rc        <= '0;
            full      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                if (wc == LAST) begin
                    wc <= '0;
                    wb <= ~wb;
                end else begin
                    wc <= wc + 1'b1;
                end
            end
            if (rd_load) begin
                out_data  <= mem[rb][rd_idx];
                out_valid <= 1'b1;
                out_last  <= (rc == LAST);
                if (rc == LAST) begin
                    rc <= '0;
                    rb <= ~rb;
                end else begin
                    rc <= rc + 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_transpose_buf.sv
// Bench for transpose_buf: block-level reference model plus directed scenarios
// for latency, streaming, back-pressure, random handshakes, reset and N=4 variants.
module tb_transpose_buf;

    localparam int N8 = 8;
    localparam int NN = N8 * N8;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] in_data;
    logic       in_load;
    logic       in_ready;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [1:0] full_cnt;

    logic [11:0] s_in;
    logic        s_load;
    logic        one;
    logic [11:0] r_out, c_out;
    logic        r_inr, c_inr, r_valid, c_valid, r_last, c_last;
    logic [1:0]  r_cnt, c_cnt;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    transpose_buf #(.DATA_WIDTH(10), .N(8), .MODE(1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_load(in_load), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .full_cnt(full_cnt)
    );

    transpose_buf #(.DATA_WIDTH(12), .N(4), .MODE(0)) dut_row (
        .clk(clk), .rst(rst), .in_data(s_in), .in_load(s_load), .in_ready(r_inr),
        .out_data(r_out), .out_valid(r_valid), .out_ready(one),
        .out_last(r_last), .full_cnt(r_cnt)
    );

    transpose_buf #(.DATA_WIDTH(12), .N(4), .MODE(1)) dut_col (
        .clk(clk), .rst(rst), .in_data(s_in), .in_load(s_load), .in_ready(c_inr),
        .out_data(c_out), .out_valid(c_valid), .out_ready(one),
        .out_last(c_last), .full_cnt(c_cnt)
    );

    task automatic check(input string name, input int got, input int exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Reference model: whole blocks are collected, then their output order is
    // generated directly from the transpose definition.
    int cur[$];
    int expd[$];
    bit expl[$];
    int completed = 0;
    int xfers = 0;
    bit prev_stall = 1'b0;
    int prev_d = 0;
    int prev_l = 0;

    always @(posedge clk) begin
        bit r, fi, fo;
        int di, dout, lout, pend, got_d;
        bit got_l;
        r    = rst;
        fi   = in_load && in_ready;
        di   = in_data;
        fo   = out_valid && out_ready;
        dout = out_data;
        lout = out_last;
        if (prev_stall && !r) begin
            check("stall_data_hold", dout, prev_d);
            check("stall_last_hold", lout, prev_l);
        end
        prev_stall = out_valid && !out_ready && !r;
        prev_d = dout;
        prev_l = lout;
        #1;
        if (r) begin
            cur.delete();
            expd.delete();
            expl.delete();
            completed = 0;
            xfers = 0;
        end else begin
            if (fo) begin
                if (expd.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    got_d = expd.pop_front();
                    got_l = expl.pop_front();
                    check("out_data", dout, got_d);
                    check("out_last", lout, int'(got_l));
                end
                xfers++;
            end
            if (fi) begin
                cur.push_back(di);
                if (cur.size() == NN) begin
                    for (int p = 0; p < NN; p++) begin
                        expd.push_back(cur[(p % N8) * N8 + p / N8]);
                        expl.push_back(p == NN - 1);
                    end
                    cur.delete();
                    completed++;
                end
            end
        end
        pend = completed - (xfers + int'(out_valid)) / NN;
        check("full_cnt", int'(full_cnt), pend);
        check("in_ready", int'(in_ready), int'(pend < 2));
    end

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((out_valid || full_cnt != 0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(out_valid || full_cnt != 0), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int col_exp [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
        int rcnt, ccnt, sent, acc, nout, gaps, inr_low;
        int lp[$];
        bit seen, found, prev_ir;

        rst = 1'b1; in_load = 1'b0; in_data = '0; out_ready = 1'b0;
        s_in = '0; s_load = 1'b0; one = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_last", int'(out_last), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_full_cnt", int'(full_cnt), 0);
        rst = 1'b0;

        // N=4 variants, row-major and column-major
        for (int i = 0; i < 16; i++) begin
            s_load = 1'b1;
            s_in = 12'(i);
            @(negedge clk);
        end
        s_load = 1'b0;
        rcnt = 0;
        ccnt = 0;
        for (int cyc = 0; cyc < 100 && (rcnt < 16 || ccnt < 16); cyc++) begin
            @(negedge clk);
            if (r_valid && rcnt < 16) begin
                check("n4_row_data", int'(r_out), rcnt);
                check("n4_row_last", int'(r_last), int'(rcnt == 15));
                rcnt++;
            end
            if (c_valid && ccnt < 16) begin
                check("n4_col_data", int'(c_out), col_exp[ccnt]);
                check("n4_col_last", int'(c_last), int'(ccnt == 15));
                ccnt++;
            end
        end
        check("n4_row_count", rcnt, 16);
        check("n4_col_count", ccnt, 16);

        // Single block transpose, latency
        out_ready = 1'b1;
        for (int i = 0; i < NN; i++) begin
            in_load = 1'b1;
            in_data = 10'(i);
            @(negedge clk);
        end
        in_load = 1'b0;
        check("lat_valid_k", int'(out_valid), 0);
        check("lat_full_k", int'(full_cnt), 1);
        @(negedge clk);
        check("lat_valid_k1", int'(out_valid), 1);
        check("first_out", int'(out_data), 0);
        @(negedge clk);
        check("second_out", int'(out_data), 8);
        repeat (7) @(negedge clk);
        check("ninth_out", int'(out_data), 1);
        wait_drain("drain_single");

        // Streaming three blocks
        sent = 0; nout = 0; gaps = 0; inr_low = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 400 && nout < 3 * NN; cyc++) begin
            if (out_valid) begin
                seen = 1'b1;
                if (out_last) lp.push_back(nout);
                nout++;
            end else if (seen) begin
                gaps++;
            end
            if (sent < 3 * NN) begin
                in_load = 1'b1;
                in_data = 10'(sent);
                if (!in_ready) inr_low++;
                else sent++;
            end else begin
                in_load = 1'b0;
            end
            @(negedge clk);
        end
        in_load = 1'b0;
        check("stream_in_ready_low", inr_low, 0);
        check("stream_gaps", gaps, 0);
        check("stream_outputs", nout, 3 * NN);
        check("stream_last_count", lp.size(), 3);
        if (lp.size() == 3) begin
            check("stream_last0", lp[0], 63);
            check("stream_last1", lp[1], 127);
            check("stream_last2", lp[2], 191);
        end
        wait_drain("drain_stream");

        // Back-pressure
        out_ready = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            in_load = 1'b1;
            in_data = 10'(acc);
            if (!in_ready) break;
            acc++;
            @(negedge clk);
        end
        in_load = 1'b0;
        check("bp_accepted", acc, 128);
        check("bp_full_cnt", int'(full_cnt), 2);
        check("bp_out_valid", int'(out_valid), 1);
        check("bp_out_data", int'(out_data), 0);
        repeat (3) @(negedge clk);
        check("bp_out_data_held", int'(out_data), 0);
        out_ready = 1'b1;
        found = 1'b0;
        prev_ir = in_ready;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (out_valid && out_last) begin
                found = 1'b1;
                check("bp_in_ready_before", int'(prev_ir), 0);
                check("bp_in_ready_after", int'(in_ready), 1);
                break;
            end
            prev_ir = in_ready;
            @(negedge clk);
        end
        check("bp_release_seen", int'(found), 1);
        wait_drain("drain_bp");

        // Random handshakes
        void'($urandom(32'd2024));
        sent = 0;
        for (int cyc = 0; cyc < 3000 && sent < 3 * NN; cyc++) begin
            in_load = ($urandom_range(0, 9) < 7);
            in_data = 10'(sent * 5 + 1);
            out_ready = ($urandom_range(0, 9) < 6);
            if (in_load && in_ready) sent++;
            @(negedge clk);
        end
        in_load = 1'b0;
        out_ready = 1'b1;
        check("rand_sent", sent, 3 * NN);
        wait_drain("drain_rand");

        // Reset mid-block
        for (int i = 0; i < 20; i++) begin
            in_load = 1'b1;
            in_data = 10'(500 + i);
            @(negedge clk);
        end
        in_load = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_valid", int'(out_valid), 0);
        check("rst_mid_in_ready", int'(in_ready), 1);
        check("rst_mid_full_cnt", int'(full_cnt), 0);
        for (int i = 0; i < NN; i++) begin
            in_load = 1'b1;
            in_data = 10'(i);
            @(negedge clk);
        end
        in_load = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            if (out_valid) found = 1'b1;
            else @(negedge clk);
        end
        check("rst_mid_first_seen", int'(found), 1);
        check("rst_mid_first_out", int'(out_data), 0);
        wait_drain("drain_rst");

        check("model_queue_empty", expd.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/transpose_buf.md
# transpose_buf

Parametrised double-buffered (ping-pong) transpose buffer between the row-DCT and column-DCT PE arrays. Accepts one row-major sample per cycle and returns each completed N×N block in column-major order (transpose) or row-major order (pass-through) at one sample per cycle. Valid/ready handshakes on both sides replace the fixed-schedule load/valid pair of the previous generation and add output back-pressure.

## Interface
- DATA_WIDTH, 10, sample width in bits
- N, 8, block edge; a block is N*N samples; N is a power of two, 2..16
- MODE, 1, 1 = transposed read (column-major); 0 = straight read (row-major)
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_data  in  DATA_WIDTH  input sample, row-major order within a block
- in_load  in  1  in_data is valid this cycle
- in_ready  out  1  buffer can accept a sample; a transfer occurs when in_load && in_ready
- out_data  out  DATA_WIDTH  output sample (registered)
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts out_data; a transfer occurs when out_valid && out_ready
- out_last  out  1  out_data is the final sample of its block
- full_cnt  out  2  number of banks holding a complete, not fully drained block (0..2)

## Operation
- Two banks of N*N words each. Writes use a register-file-style array; reads are combinational into the output register.
- Write side: write bank pointer wb, write counter wc (0..N*N-1). On each input transfer, mem[wb][wc] <= in_data and wc increments.
  - When wc = N*N-1 transfers: wc <= 0, full[wb] <= 1, wb toggles.
  - in_ready = !full[wb], computed from registered state only.
- Read side: read bank pointer rb, read counter rc. Read index is (rc mod N)*N + rc/N for MODE=1, and rc for MODE=0.
  - The output register loads when full[rb] && (!out_valid || out_ready).
  - On load: out_data <= mem[rb][index], out_valid <= 1, out_last <= (rc = N*N-1), rc increments.
  - Loading rc = N*N-1 sets rc <= 0, full[rb] <= 0 (bank released on that same edge), and rb toggles.
  - If out_valid && out_ready and no load occurs, out_valid <= 0 and out_last <= 0.
- Per-bank state is EMPTY (full=0, not write target), FILLING (write target), FULL/DRAINING (full=1).
  - Transitions: FILLING→FULL on the last write; DRAINING→EMPTY on the last read load.
  - The writer never targets a bank with full=1.
- full_cnt = full[0] + full[1].
- Stall behaviour: while out_valid && !out_ready, out_data and out_last are held stable.
- in_data arriving while in_ready = 0 is ignored.
- Reset values: wb = rb = 0, wc = rc = 0, full = 00, out_valid = 0, out_last = 0, out_data = 0, in_ready = 1, full_cnt = 0. Memory contents are not reset.
- Reset mid-operation discards all partial and complete blocks. The next accepted sample is sample 0 of a block in bank 0.

## Timing
- Input-to-output latency: last sample of a block accepted at edge k; full set at edge k; first output sample loaded at edge k+1 (out_valid high in cycle k+1), provided the reader is idle.
- Throughput is one sample/cycle each side. With out_ready held at 1 and in_load held at 1, in_ready never deasserts.
  - Bank release at edge k coincides with the other bank's fill completing at edge k; the released bank is writable in cycle k+1.
- Simultaneous last write into bank A and last read from bank B on the same edge are both legal: full becomes {A=1, B=0}.
- A bank released at edge k is seen by in_ready in cycle k+1, not cycle k. There is no combinational path from out_ready to in_ready.
- out_valid falls on the edge after the final accepted transfer when no further full bank exists.

## Test plan
- Transpose, N=8, MODE=1: feed one block with in_data = index 0..63 continuously, out_ready=1 → out_valid first high 1 cycle after sample 63; outputs 0,8,16,…,56,1,9,…,63; out_last high only on 63; full_cnt returns to 0.
- Streaming: 3 back-to-back blocks (values = 64*b + index), in_load=1, out_ready=1 → in_ready constantly 1; 192 outputs with no out_valid gaps after the first; out_last on outputs 63, 127, 191.
- Back-pressure: out_ready=0, stream input → in_ready falls after exactly 128 accepted samples and full_cnt=2; out_data holds 0. Then release out_ready → all 128 outputs in correct order; in_ready rises the cycle after the first bank drains.
- Random in_load/out_ready toggling (seeded) → output sequence equals the reference transpose of the input; no sample lost or duplicated; out_data stable whenever stalled.
- Reset mid-block: assert rst after 20 samples of block 0 → next cycle out_valid=0, in_ready=1, full_cnt=0. A fresh 64-sample block then produces the correct transpose starting from value 0.
- Parameter variants: N=4, MODE=0, DATA_WIDTH=12, input 0..15 → output 0..15 in row-major order. N=4, MODE=1 → output 0,4,8,12,1,5,…,15.
